// File: rtl/sort8_loader.sv
// -----------------------------------------------------------------------------
// sort8_loader
//
// Packs a serial byte stream into 8-byte parallel frames for the 8-input
// pipelined byte sorter. It also regenerates frame valid/count at the sorter
// output through a delay line whose depth matches the sorter latency.
//
// Ports:
//   clk       : clock, all logic on rising edge
//   rst       : synchronous active-high reset
//   in_valid  : in_data valid this cycle
//   in_ready  : loader can accept a byte (combinational, = !in_flush)
//   in_data   : stream byte
//   in_flush  : close the current partial frame now (byte ignored this cycle)
//   x0..x7    : registered parallel frame to sorter
//   x_valid   : one-cycle pulse, x0..x7 hold a new frame
//   x_count   : real elements in frame (1..8), meaningful with x_valid
//   y_valid   : x_valid delayed SORT_LAT cycles
//   y_count   : x_count delayed SORT_LAT cycles
//   frames    : frames emitted, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module sort8_loader #(
    parameter logic [7:0] PAD      = 8'hFF,
    parameter int         SORT_LAT = 6,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_flush,
    output logic [7:0]       x0,
    output logic [7:0]       x1,
    output logic [7:0]       x2,
    output logic [7:0]       x3,
    output logic [7:0]       x4,
    output logic [7:0]       x5,
    output logic [7:0]       x6,
    output logic [7:0]       x7,
    output logic             x_valid,
    output logic [3:0]       x_count,
    output logic             y_valid,
    output logic [3:0]       y_count,
    output logic [CNT_W-1:0] frames
);

    localparam logic [CNT_W-1:0] FRAME_INC = 1;
    localparam int               DL_W      = 5;  // {valid, count[3:0]}

    logic [2:0]             idx_q, idx_d;
    logic [7:0]             c_q [8];
    logic [7:0]             c_d [8];
    logic [7:0]             x_q [8];
    logic [7:0]             x_d [8];
    logic                   x_valid_q, x_valid_d;
    logic [3:0]             x_count_q, x_count_d;
    logic [CNT_W-1:0]       frames_q, frames_d;
    logic [SORT_LAT*DL_W-1:0] dl_q, dl_d;
    logic                   accept;

    // A flush claims the cycle outright; the byte on in_data is left for
    // the source to present again.
    assign in_ready = !in_flush;
    assign accept   = in_valid && !in_flush;

    always_comb begin
        idx_d     = idx_q;
        c_d       = c_q;
        x_d       = x_q;
        x_valid_d = 1'b0;
        x_count_d = x_count_q;
        frames_d  = frames_q;

        if (in_flush) begin
            // Flushing an empty collector is a no-op.
            if (idx_q != 3'd0) begin
                for (int i = 0; i < 8; i++) begin
                    x_d[i] = (3'(i) < idx_q) ? c_q[i] : PAD;
                end
                x_valid_d = 1'b1;
                x_count_d = {1'b0, idx_q};
                idx_d     = 3'd0;
                frames_d  = frames_q + FRAME_INC;
            end
        end else if (accept) begin
            c_d[idx_q] = in_data;
            if (idx_q == 3'd7) begin
                // The eighth byte bypasses the collector straight into x7.
                for (int i = 0; i < 7; i++) begin
                    x_d[i] = c_q[i];
                end
                x_d[7]    = in_data;
                x_valid_d = 1'b1;
                x_count_d = 4'd8;
                idx_d     = 3'd0;
                frames_d  = frames_q + FRAME_INC;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    // Delay line: stage 0 captures the registered frame strobe, each later
    // stage takes the one before it.
    genvar gi;
    generate
        for (gi = 0; gi < SORT_LAT; gi++) begin : g_dl
            if (gi == 0) begin : g_head
                assign dl_d[DL_W-1:0] = {x_valid_q, x_count_q};
            end else begin : g_tail
                assign dl_d[gi*DL_W +: DL_W] = dl_q[(gi-1)*DL_W +: DL_W];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                c_q[i] <= 8'd0;
                x_q[i] <= 8'd0;
            end
            x_valid_q <= 1'b0;
            x_count_q <= 4'd0;
            frames_q  <= '0;
            dl_q      <= '0;
        end else begin
            idx_q     <= idx_d;
            c_q       <= c_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            x_count_q <= x_count_d;
            frames_q  <= frames_d;
            dl_q      <= dl_d;
        end
    end

    assign x0      = x_q[0];
    assign x1      = x_q[1];
    assign x2      = x_q[2];
    assign x3      = x_q[3];
    assign x4      = x_q[4];
    assign x5      = x_q[5];
    assign x6      = x_q[6];
    assign x7      = x_q[7];
    assign x_valid = x_valid_q;
    assign x_count = x_count_q;
    assign frames  = frames_q;
    assign y_valid = dl_q[(SORT_LAT-1)*DL_W + 4];
    assign y_count = dl_q[(SORT_LAT-1)*DL_W +: 4];

endmodule

// File: tb/tb_sort8_loader.sv
// -----------------------------------------------------------------------------
// tb_sort8_loader
//
// Scoreboard bench for sort8_loader. Stimulus tasks keep a reference model of
// the collector; every frame event pushes the expected frame (with the cycle
// it must appear in) onto an x queue and the expected sorter-side strobe onto
// a y queue. Monitors pop and compare when the DUT raises x_valid / y_valid.
// -----------------------------------------------------------------------------
module tb_sort8_loader;

    localparam int         SORT_LAT = 6;
    localparam int         CNT_W    = 4;
    localparam logic [7:0] PAD      = 8'hFF;

    typedef struct {
        logic [63:0]      data;
        logic [3:0]       cnt;
        logic [CNT_W-1:0] frm;
        int               cyc;
    } xexp_t;

    typedef struct {
        logic [3:0] cnt;
        int         cyc;
    } yexp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'd0;
    logic             in_flush = 1'b0;
    logic [7:0]       x0, x1, x2, x3, x4, x5, x6, x7;
    logic             x_valid;
    logic [3:0]       x_count;
    logic             y_valid;
    logic [3:0]       y_count;
    logic [CNT_W-1:0] frames;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    xexp_t xq[$];
    yexp_t yq[$];

    // reference model of the collector
    logic [7:0]       slot_m [8];
    int               idx_m    = 0;
    logic [CNT_W-1:0] frames_m = '0;

    sort8_loader #(.PAD(PAD), .SORT_LAT(SORT_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_flush(in_flush),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
        .x_valid(x_valid), .x_count(x_count),
        .y_valid(y_valid), .y_count(y_count),
        .frames(frames)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Push an expected frame for an event taking effect at the coming edge.
    task automatic push_frame(input int cnt);
        xexp_t xe;
        yexp_t ye;
        xe.data = '0;
        for (int i = 0; i < 8; i++) begin
            xe.data[8*i +: 8] = (i < cnt) ? slot_m[i] : PAD;
        end
        frames_m = frames_m + 1'b1;
        xe.cnt = 4'(cnt);
        xe.frm = frames_m;
        xe.cyc = cyc + 1;
        ye.cnt = 4'(cnt);
        ye.cyc = cyc + 1 + SORT_LAT;
        xq.push_back(xe);
        yq.push_back(ye);
        idx_m = 0;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = b;
        in_flush = 1'b0;
        #1 check("in_ready_stream", in_ready, 1'b1);
        slot_m[idx_m] = b;
        if (idx_m == 7) push_frame(8);
        else idx_m++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_flush = 1'b0;
        end
    endtask

    task automatic flush(input logic v, input logic [7:0] b);
        @(posedge clk); #1;
        in_flush = 1'b1;
        in_valid = v;
        in_data  = b;
        #1 check("in_ready_flush", in_ready, 1'b0);
        if (idx_m != 0) push_frame(idx_m);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_flush = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        xq.delete();
        yq.delete();
        idx_m    = 0;
        frames_m = '0;
        check("rst_x", {x7, x6, x5, x4, x3, x2, x1, x0}, 64'd0);
        check("rst_x_valid", x_valid, 1'b0);
        check("rst_x_count", x_count, 4'd0);
        check("rst_y_valid", y_valid, 1'b0);
        check("rst_y_count", y_count, 4'd0);
        check("rst_frames", frames, '0);
    endtask

    // x-side monitor
    always @(negedge clk) begin
        if (!rst && x_valid) begin
            if (xq.size() == 0) begin
                check("x_unexpected", 1'b1, 1'b0);
            end else begin
                xexp_t e;
                e = xq.pop_front();
                check("x_cycle", cyc, e.cyc);
                check("x_data", {x7, x6, x5, x4, x3, x2, x1, x0}, e.data);
                check("x_count", x_count, e.cnt);
                check("frames", frames, e.frm);
            end
        end
    end

    // y-side monitor
    always @(negedge clk) begin
        if (!rst && y_valid) begin
            if (yq.size() == 0) begin
                check("y_unexpected", 1'b1, 1'b0);
            end else begin
                yexp_t e;
                e = yq.pop_front();
                check("y_cycle", cyc, e.cyc);
                check("y_count", y_count, e.cnt);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1 [8];
        t1 = '{8'h07, 8'h05, 8'h03, 8'h01, 8'h08, 8'h06, 8'h04, 8'h02};

        do_reset();

        // single full frame
        for (int i = 0; i < 8; i++) send(t1[i]);
        idle(SORT_LAT + 4);
        check("frames_after_t1", frames, 4'd1);

        // 24 bytes back-to-back: three frames 8 cycles apart
        for (int i = 0; i < 24; i++) send(8'($urandom_range(0, 255)));
        idle(SORT_LAT + 4);
        check("frames_after_t2", frames, 4'd4);

        // partial frame then flush, next byte lands in slot 0
        send(8'h10); send(8'h20); send(8'h30);
        flush(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) send(8'h40 + 8'(i));
        idle(SORT_LAT + 4);

        // flush with empty collector: nothing happens
        flush(1'b0, 8'h00);
        idle(3);
        check("frames_flush_idx0", frames, frames_m);
        // flush with a byte offered at idx 0: byte dropped, no frame
        flush(1'b1, 8'hAA);
        idle(3);
        check("frames_flush_valid_idx0", frames, frames_m);
        // flush with a byte offered mid-frame: frame of 2, byte re-sent to slot 0
        send(8'h11); send(8'h22);
        flush(1'b1, 8'hAA);
        send(8'hAA);
        for (int i = 0; i < 7; i++) send(8'hB0 + 8'(i));
        idle(SORT_LAT + 4);

        // reset with a frame in flight and 5 bytes collected
        for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i));
        for (int i = 0; i < 5; i++) send(8'hD0 + 8'(i));
        do_reset();
        for (int i = 0; i < SORT_LAT; i++) begin
            @(negedge clk);
            check("y_quiet_after_rst", y_valid, 1'b0);
        end
        for (int i = 0; i < 8; i++) send(8'hE0 + 8'(i));
        idle(SORT_LAT + 4);
        check("frames_after_rst", frames, 4'd1);

        // 17 frames with 4-bit counter: wraps to 1
        do_reset();
        for (int i = 0; i < 17 * 8; i++) send(8'($urandom_range(0, 255)));
        idle(SORT_LAT + 4);
        check("frames_wrap", frames, 4'd1);

        // alternating valid for 16 cycles: one frame
        for (int i = 0; i < 8; i++) begin
            send(8'(i * 3));
            idle(1);
        end
        idle(SORT_LAT + 4);
        check("frames_alternate", frames, 4'd2);

        check("xq_drained", 64'(xq.size()), 64'd0);
        check("yq_drained", 64'(yq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
